// File: rtl/hamming_encode_engine.sv
// rtl/hamming_encode_engine.sv - memory-walking Hamming SECDED encoder (11-bit data -> 16-bit codeword)
module hamming_encode_engine #(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int AW       = 8
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          start_i,
    output logic          done_o,
    output logic          busy_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_wen_o,
    output logic [7:0]    mem_wdata_o,
    input  logic [7:0]    mem_rdata_i
);
    localparam int IW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MSG - 1);
    localparam logic [AW-1:0] SRC_A    = AW'(SRC_BASE);
    localparam logic [AW-1:0] DST_A    = AW'(DST_BASE);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    lo_q, lo_d;
    logic [2:0]    hi_q, hi_d;
    logic          done_q, done_d;

    logic [11:1]   d;
    logic          p8, p4, p2, p1, p0;
    logic [15:0]   cw;
    logic [AW-1:0] off;

    // Only the three meaningful high-byte bits are kept; hi[7:3] is dropped at capture.
    assign d  = {hi_q, lo_q};
    assign p8 = ^d[11:5];
    assign p4 = (^d[11:8]) ^ (^d[4:2]);
    assign p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    assign p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    assign p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
    assign cw = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};

    assign off = AW'({idx_q, 1'b0});

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        done_d      = done_q;
        mem_addr_o  = '0;
        mem_wen_o   = 1'b0;
        mem_wdata_o = '0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RD_LO;
                    idx_d   = '0;
                    done_d  = 1'b0;
                end
            end
            RD_LO: begin
                mem_addr_o = SRC_A + off;
                lo_d       = mem_rdata_i;
                state_d    = RD_HI;
            end
            RD_HI: begin
                mem_addr_o = SRC_A + off + AW'(1);
                hi_d       = mem_rdata_i[2:0];
                state_d    = WR_LO;
            end
            WR_LO: begin
                mem_addr_o  = DST_A + off;
                mem_wen_o   = 1'b1;
                mem_wdata_o = cw[7:0];
                state_d     = WR_HI;
            end
            WR_HI: begin
                mem_addr_o  = DST_A + off + AW'(1);
                mem_wen_o   = 1'b1;
                mem_wdata_o = cw[15:8];
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = RD_LO;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
endmodule

// File: tb/tb_hamming_encode_engine.sv
// tb/tb_hamming_encode_engine.sv - randomized self-checking bench for hamming_encode_engine
module tb_hamming_encode_engine;
    localparam int NUM_MSG  = 15;
    localparam int SRC_BASE = 0;
    localparam int DST_BASE = 30;
    localparam int AW       = 8;

    logic          clk = 1'b0;
    logic          reset, start;
    logic          done, busy, mem_wen;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata, mem_rdata;

    logic [7:0]    mem [0:255];
    logic          tb_we;
    logic [7:0]    tb_addr, tb_data;
    int            wr_cnt, bad_wr;

    int            n_chk, n_fail;
    logic [7:0]    lo_v [NUM_MSG];
    logic [7:0]    hi_v [NUM_MSG];
    logic [7:0]    src_save [0:DST_BASE-1];

    hamming_encode_engine #(
        .NUM_MSG(NUM_MSG), .SRC_BASE(SRC_BASE), .DST_BASE(DST_BASE), .AW(AW)
    ) dut (
        .clock_i(clk), .reset_i(reset), .start_i(start), .done_o(done), .busy_o(busy),
        .mem_addr_o(mem_addr), .mem_wen_o(mem_wen), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wen) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
            if (mem_addr < 8'(DST_BASE) || mem_addr > 8'(DST_BASE + 2*NUM_MSG - 1))
                bad_wr <= bad_wr + 1;
        end else if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int a, input logic [7:0] v);
        tb_we   = 1'b1;
        tb_addr = 8'(a);
        tb_data = v;
        tick();
        tb_we   = 1'b0;
    endtask

    // Reference: data bits fill the non-power-of-two positions 1..15 in order,
    // parity at position p covers every position whose index has bit p set.
    function automatic logic [15:0] encode_ref(input logic [10:0] dv);
        logic [15:0] c = '0;
        int k = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = dv[k];
                k++;
            end
        end
        for (int p = 1; p < 16; p = p * 2) begin
            logic par = 1'b0;
            for (int pos = 1; pos < 16; pos++)
                if ((pos & p) != 0 && pos != p) par ^= c[pos];
            c[p] = par;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic void decode_ref(input logic [15:0] cin, output logic [1:0] flags,
                                       output logic [10:0] dout);
        logic [15:0] c = cin;
        int syn = 0;
        int k = 0;
        logic ov = ^cin;
        for (int pos = 1; pos < 16; pos++) if (c[pos]) syn ^= pos;
        if (ov) begin
            flags  = 2'b01;
            c[syn] = ~c[syn];
        end else if (syn != 0) begin
            flags = 2'b10;
        end else begin
            flags = 2'b00;
        end
        dout = '0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                dout[k] = c[pos];
                k++;
            end
        end
    endfunction

    function automatic logic [10:0] msg_data(input int i);
        return {hi_v[i][2:0], lo_v[i]};
    endfunction

    function automatic logic [15:0] dst_word(input int i);
        return {mem[DST_BASE + 2*i + 1], mem[DST_BASE + 2*i]};
    endfunction

    task automatic run_engine(input int pulse_at, output int cycles);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check("done_cleared", done, 1'b0);
        cycles = 0;
        while (!done && cycles < 200) begin
            if (cycles == pulse_at) start = 1'b1;
            tick();
            start = 1'b0;
            cycles++;
        end
        check("done_latency", cycles, 61);
        check("busy_fell", busy, 1'b0);
    endtask

    task automatic check_results(input string tag);
        for (int i = 0; i < NUM_MSG; i++)
            check({tag, "_cw"}, dst_word(i), encode_ref(msg_data(i)));
        for (int a = 0; a < DST_BASE; a++)
            check({tag, "_src"}, mem[a], src_save[a]);
        check({tag, "_bad_wr"}, bad_wr, 0);
    endtask

    initial begin
        int cyc;
        int wr_snap;
        n_chk = 0; n_fail = 0; wr_cnt = 0; bad_wr = 0;
        tb_we = 1'b0; tb_addr = '0; tb_data = '0;
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        reset = 1'b1; start = 1'b0;
        repeat (3) tick();
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wen", mem_wen, 1'b0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        reset = 1'b0;
        tick();

        lo_v[0] = 8'h00; hi_v[0] = 8'h00;
        lo_v[1] = 8'hFF; hi_v[1] = 8'h07;
        lo_v[2] = 8'h01; hi_v[2] = 8'h00;
        lo_v[3] = 8'h00; hi_v[3] = 8'h04;
        lo_v[4] = 8'h00; hi_v[4] = 8'hFC;
        for (int i = 5; i < NUM_MSG; i++) begin
            lo_v[i] = 8'($urandom);
            hi_v[i] = 8'($urandom);
        end
        for (int i = 0; i < NUM_MSG; i++) begin
            poke(SRC_BASE + 2*i, lo_v[i]);
            poke(SRC_BASE + 2*i + 1, hi_v[i]);
        end
        for (int a = 0; a < DST_BASE; a++) src_save[a] = mem[a];

        run_engine(-1, cyc);
        check_results("run1");
        check("zero_lo", mem[30], 8'h00);
        check("zero_hi", mem[31], 8'h00);
        check("ones_lo", mem[32], 8'hFF);
        check("ones_hi", mem[33], 8'hFF);
        check("d001", dst_word(2), 16'h000F);
        check("d400", dst_word(3), 16'h8117);
        check("d400_ign", dst_word(4), 16'h8117);
        check("wr_cnt_run1", wr_cnt, 2*NUM_MSG);

        for (int i = 0; i < NUM_MSG; i++) begin
            logic [1:0]  fl;
            logic [10:0] dd;
            logic [15:0] c;
            int b1, b2;
            c = dst_word(i);
            decode_ref(c, fl, dd);
            check("rt0_flags", fl, 2'b00);
            check("rt0_data", dd, msg_data(i));
            b1 = $urandom_range(0, 15);
            c[b1] = ~c[b1];
            decode_ref(c, fl, dd);
            check("rt1_flags", fl, 2'b01);
            check("rt1_data", dd, msg_data(i));
            b2 = (b1 + $urandom_range(1, 15)) % 16;
            c[b2] = ~c[b2];
            decode_ref(c, fl, dd);
            check("rt2_msb", fl[1], 1'b1);
        end

        run_engine(10, cyc);
        check_results("run2_busy_pulse");
        tick();
        check("done_held", done, 1'b1);
        run_engine(-1, cyc);
        check_results("run3_repeat");

        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        check("rst_start_busy", busy, 1'b0);
        check("rst_start_done", done, 1'b0);
        tick();
        check("rst_start_idle", busy, 1'b0);

        for (int a = DST_BASE; a < DST_BASE + 2*NUM_MSG; a++) poke(a, 8'h5A);
        wr_snap = wr_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_wen", mem_wen, 1'b0);
        check("mid_rst_writes", wr_cnt - wr_snap, 10);
        wr_snap = wr_cnt;
        repeat (70) tick();
        check("post_rst_no_wr", wr_cnt - wr_snap, 0);
        check("post_rst_done", done, 1'b0);
        for (int i = 0; i < 5; i++)
            check("mid_rst_cw", dst_word(i), encode_ref(msg_data(i)));
        for (int a = 40; a < 60; a++)
            check("mid_rst_untouched", mem[a], 8'h5A);
        check("mid_rst_bad_wr", bad_wr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
